// File: rtl/gcd7_seq.sv
// Request sequencer for the 7-bit GCD core: buffers operand pairs, drives the core
// for a fixed run window, then presents the result with its operands on a valid/ready port.
module gcd7_seq #(
    parameter int WIDTH      = 7,
    parameter int DEPTH      = 4,
    parameter int RUN_CYCLES = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             core_load,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_b,
    input  logic [WIDTH-1:0] core_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_gcd,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RUN_CYCLES) + 1;
    localparam logic [AW:0]   FIFO_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] RUN_LAST  = CW'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  mem_a [DEPTH];
    logic [WIDTH-1:0]  mem_b [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic [CW-1:0]     count;
    logic              push, pop, head_zero;
    logic [WIDTH-1:0]  head_a, head_b;

    always_comb begin
        in_ready  = (fifo_cnt != FIFO_FULL);
        busy      = (state != IDLE) || (fifo_cnt != '0);
        push      = in_valid && in_ready;
        pop       = (state == IDLE) && (fifo_cnt != '0);
        head_a    = mem_a[rd_ptr];
        head_b    = mem_b[rd_ptr];
        head_zero = (head_a == '0) || (head_b == '0);
    end

    // Storage is not reset: the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fifo_cnt != '0) state_nxt = head_zero ? DONE : LOAD;
            LOAD: state_nxt = RUN;
            RUN:  if (count == '0) state_nxt = DONE;
            DONE: if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // out_valid rises the cycle after DONE is entered, which gives the 2-cycle zero path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_load <= 1'b0;
            core_a    <= '0;
            core_b    <= '0;
            out_valid <= 1'b0;
            out_gcd   <= '0;
            out_a     <= '0;
            out_b     <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        out_a <= head_a;
                        out_b <= head_b;
                        if (head_zero) begin
                            out_gcd <= head_a | head_b;
                        end else begin
                            core_a    <= head_a;
                            core_b    <= head_b;
                            core_load <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    core_load <= 1'b0;
                    count     <= RUN_LAST;
                end
                RUN: begin
                    if (count == '0) out_gcd <= core_c;
                    else             count   <= count - 1'b1;
                end
                DONE: out_valid <= !(out_valid && out_ready);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcd7_seq.sv
// Directed bench for gcd7_seq with a behavioural Euclid core attached to the core port.
module tb_gcd7_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [6:0] in_a, in_b;
    logic       core_load;
    logic [6:0] core_a, core_b, core_c;
    logic       out_valid, out_ready;
    logic [6:0] out_gcd, out_a, out_b;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int load_cnt = 0;

    logic [6:0] got_g [16];
    logic [6:0] got_a [16];
    logic [6:0] got_b [16];
    int n_got;

    gcd7_seq #(.WIDTH(7), .DEPTH(4), .RUN_CYCLES(20)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .core_load(core_load), .core_a(core_a), .core_b(core_b), .core_c(core_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_gcd(out_gcd), .out_a(out_a), .out_b(out_b), .busy(busy)
    );

    always #5 clk = ~clk;

    // Core model: one Euclid modulo step per cycle after the load strobe.
    logic [6:0] ca, cb;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ca <= '0; cb <= '0;
        end else if (core_load) begin
            ca <= core_a; cb <= core_b;
        end else if (cb != 0) begin
            ca <= cb; cb <= ca % cb;
        end
    end
    assign core_c = ca;

    always @(posedge clk) if (core_load) load_cnt <= load_cnt + 1;

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && !out_valid; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic collect(input int n, input int budget);
        logic acc;
        for (int c = 0; c < budget && n_got < n; c++) begin
            acc = in_valid && in_ready;
            if (out_valid && out_ready) begin
                got_g[n_got] = out_gcd; got_a[n_got] = out_a; got_b[n_got] = out_b;
                n_got++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else passed++;
        total++; if ({out_valid, core_load, busy} !== 3'b000) $display("FAIL rst_ctrl got %b want 000", {out_valid, core_load, busy}); else passed++;
        total++; if ({out_gcd, out_a, out_b, core_a, core_b} !== 35'd0) $display("FAIL rst_data got %h want 0", {out_gcd, out_a, out_b, core_a, core_b}); else passed++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        int k, l0;
        l0 = load_cnt;
        in_valid = 1'b1; in_a = 7'd12; in_b = 7'd18;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 60) begin
            @(posedge clk); #1; k++;
            if (k == 1) begin
                total++; if (core_load !== 1'b1) $display("FAIL t1_load_edge got %b want 1", core_load); else passed++;
            end
        end
        total++; if (k !== 23) $display("FAIL t1_latency got %0d want 23", k); else passed++;
        total++; if (load_cnt - l0 !== 1) $display("FAIL t1_load_pulses got %0d want 1", load_cnt - l0); else passed++;
        total++; if ({out_gcd, out_a, out_b} !== {7'd6, 7'd12, 7'd18}) $display("FAIL t1_result got %0d/%0d/%0d want 6/12/18", out_gcd, out_a, out_b); else passed++;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) $display("FAIL t1_valid_fall got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_zero_bypass;
        int k, l0;
        logic [6:0] va [2];
        logic [6:0] vb [2];
        logic [6:0] vg [2];
        va[0] = 7'd0; vb[0] = 7'd9; vg[0] = 7'd9;
        va[1] = 7'd0; vb[1] = 7'd0; vg[1] = 7'd0;
        l0 = load_cnt;
        for (int p = 0; p < 2; p++) begin
            in_valid = 1'b1; in_a = va[p]; in_b = vb[p];
            @(posedge clk); #1;
            in_valid = 1'b0;
            k = 0;
            while (!out_valid && k < 60) begin
                @(posedge clk); #1; k++;
            end
            total++; if (k !== 2) $display("FAIL t2_latency[%0d] got %0d want 2", p, k); else passed++;
            total++; if ({out_gcd, out_a, out_b} !== {vg[p], va[p], vb[p]}) $display("FAIL t2_result[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", p, out_gcd, out_a, out_b, vg[p], va[p], vb[p]); else passed++;
            @(posedge clk); #1;
        end
        total++; if (load_cnt - l0 !== 0) $display("FAIL t2_no_load got %0d want 0", load_cnt - l0); else passed++;
    endtask

    task automatic test_back_to_back;
        logic [6:0] va [3];
        logic [6:0] vb [3];
        logic [6:0] vg [3];
        va[0] = 7'd127; vb[0] = 7'd127; vg[0] = 7'd127;
        va[1] = 7'd64;  vb[1] = 7'd96;  vg[1] = 7'd32;
        va[2] = 7'd7;   vb[2] = 7'd5;   vg[2] = 7'd1;
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1; in_a = va[p]; in_b = vb[p];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_got = 0;
        collect(3, 300);
        total++; if (n_got !== 3) $display("FAIL t3_count got %0d want 3", n_got); else passed++;
        for (int p = 0; p < 3; p++) begin
            total++; if ({got_g[p], got_a[p], got_b[p]} !== {vg[p], va[p], vb[p]}) $display("FAIL t3_result[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", p, got_g[p], got_a[p], got_b[p], vg[p], va[p], vb[p]); else passed++;
        end
    endtask

    task automatic test_stall;
        logic [6:0] va [6];
        logic [6:0] vb [6];
        logic [6:0] vg [6];
        va[0] = 7'd12;  vb[0] = 7'd18;  vg[0] = 7'd6;
        va[1] = 7'd0;   vb[1] = 7'd5;   vg[1] = 7'd5;
        va[2] = 7'd35;  vb[2] = 7'd21;  vg[2] = 7'd7;
        va[3] = 7'd100; vb[3] = 7'd75;  vg[3] = 7'd25;
        va[4] = 7'd9;   vb[4] = 7'd28;  vg[4] = 7'd1;
        va[5] = 7'd48;  vb[5] = 7'd36;  vg[5] = 7'd12;
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++) begin
            in_valid = 1'b1; in_a = va[p]; in_b = vb[p];
            @(posedge clk); #1;
        end
        in_a = va[5]; in_b = vb[5];
        total++; if (in_ready !== 1'b0) $display("FAIL t4_full got in_ready=%b want 0", in_ready); else passed++;
        wait_valid(100);
        total++; if (out_valid !== 1'b1) $display("FAIL t4_valid_timeout got %b want 1", out_valid); else passed++;
        repeat (10) @(posedge clk);
        #1;
        total++; if ({out_valid, out_gcd, out_a, out_b} !== {1'b1, 7'd6, 7'd12, 7'd18}) $display("FAIL t4_stable got %b %0d/%0d/%0d want 1 6/12/18", out_valid, out_gcd, out_a, out_b); else passed++;
        total++; if ({in_ready, busy} !== 2'b01) $display("FAIL t4_stall_flags got %b want 01", {in_ready, busy}); else passed++;
        out_ready = 1'b1;
        n_got = 0;
        collect(6, 600);
        total++; if (n_got !== 6) $display("FAIL t4_count got %0d want 6", n_got); else passed++;
        for (int p = 0; p < 6; p++) begin
            total++; if ({got_g[p], got_a[p], got_b[p]} !== {vg[p], va[p], vb[p]}) $display("FAIL t4_result[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", p, got_g[p], got_a[p], got_b[p], vg[p], va[p], vb[p]); else passed++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_abort;
        int seen, l0;
        logic [6:0] va [3];
        logic [6:0] vb [3];
        va[0] = 7'd12; vb[0] = 7'd18;
        va[1] = 7'd6;  vb[1] = 7'd4;
        va[2] = 7'd10; vb[2] = 7'd15;
        for (int p = 0; p < 3; p++) begin
            in_valid = 1'b1; in_a = va[p]; in_b = vb[p];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++; if ({busy, out_valid} !== 2'b10) $display("FAIL t5_midrun got %b want 10", {busy, out_valid}); else passed++;
        rst = 1'b1;
        #1;
        total++; if ({in_ready, busy, out_valid, core_load} !== 4'b1000) $display("FAIL t5_abort_flags got %b want 1000", {in_ready, busy, out_valid, core_load}); else passed++;
        total++; if ({out_gcd, out_a, out_b, core_a, core_b} !== 35'd0) $display("FAIL t5_abort_data got %h want 0", {out_gcd, out_a, out_b, core_a, core_b}); else passed++;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        l0 = load_cnt; seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++; if (seen + load_cnt - l0 !== 0) $display("FAIL t5_discarded got %0d events want 0", seen + load_cnt - l0); else passed++;
        in_valid = 1'b1; in_a = 7'd8; in_b = 7'd12;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(60);
        total++; if ({out_valid, out_gcd, out_a, out_b} !== {1'b1, 7'd4, 7'd8, 7'd12}) $display("FAIL t5_after got %b %0d/%0d/%0d want 1 4/8/12", out_valid, out_gcd, out_a, out_b); else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_push_pop;
        logic [6:0] va [5];
        logic [6:0] vb [5];
        logic [6:0] vg [5];
        va[0] = 7'd21; vb[0] = 7'd14;  vg[0] = 7'd7;
        va[1] = 7'd0;  vb[1] = 7'd3;   vg[1] = 7'd3;
        va[2] = 7'd15; vb[2] = 7'd10;  vg[2] = 7'd5;
        va[3] = 7'd44; vb[3] = 7'd121; vg[3] = 7'd11;
        va[4] = 7'd81; vb[4] = 7'd27;  vg[4] = 7'd27;
        out_ready = 1'b0;
        for (int p = 0; p < 4; p++) begin
            in_valid = 1'b1; in_a = va[p]; in_b = vb[p];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_valid(100);
        total++; if ({out_valid, out_gcd, in_ready} !== {1'b1, 7'd7, 1'b1}) $display("FAIL t6_first got %b %0d %b want 1 7 1", out_valid, out_gcd, in_ready); else passed++;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_a = va[4]; in_b = vb[4];
        total++; if (in_ready !== 1'b1) $display("FAIL t6_ready_before got %b want 1", in_ready); else passed++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if ({in_ready, out_a, out_b} !== {1'b1, 7'd0, 7'd3}) $display("FAIL t6_same_cycle got %b %0d/%0d want 1 0/3", in_ready, out_a, out_b); else passed++;
        n_got = 0;
        collect(4, 400);
        total++; if (n_got !== 4) $display("FAIL t6_count got %0d want 4", n_got); else passed++;
        for (int p = 0; p < 4; p++) begin
            total++; if ({got_g[p], got_a[p], got_b[p]} !== {vg[p+1], va[p+1], vb[p+1]}) $display("FAIL t6_result[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", p, got_g[p], got_a[p], got_b[p], vg[p+1], va[p+1], vb[p+1]); else passed++;
        end
        repeat (5) @(posedge clk);
        #1;
        total++; if ({busy, out_valid} !== 2'b00) $display("FAIL t6_drained got %b want 00", {busy, out_valid}); else passed++;
    endtask

    initial begin
        test_reset;
        test_single;
        test_zero_bypass;
        test_back_to_back;
        test_stall;
        test_reset_abort;
        test_push_pop;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
